// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared types for the set-associative instruction cache.
//   - addr_t, bus size/length/burst encodings reused from the bus fabric
//   - ibus (fetch side) and cbus (interconnect side) request/response structs
//   - icache_state_t controller states
//   - width helpers for the offset and index fields of an address
package icache_sa_pkg;

  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Burst length encoded as beats-1.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    addr_t       addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    REFILL   = 3'd2,
    RESPOND  = 3'd3,
    UNCACHED = 3'd4
  } icache_state_t;

  // Byte-offset width of a line of line_beats 64-bit beats.
  function automatic int ofs_width(input int line_beats);
    return $clog2(8 * line_beats);
  endfunction

  // Set-index width.
  function automatic int idx_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

endpackage

// File: rtl/icache_way_ram.sv
// icache_way_ram: storage for one way of the instruction cache.
//   Tag array (NUM_SETS x TAG_W) and data array (NUM_SETS*LINE_BEATS x 64)
//   are plain arrays with registered reads so they map onto block RAM.
//   Valid bits live in flops so reset can clear every line at once.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rd_en/rd_idx/rd_beat  read request; rd_valid/rd_tag/rd_data one cycle later
//   wr_en/wr_idx/wr_beat/wr_data  data beat write
//   tag_we/wr_tag         tag write at wr_idx, also marks the line valid
module icache_way_ram
  import icache_sa_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4,
  parameter int TAG_W      = 23,
  localparam int IDX_W     = idx_width(NUM_SETS),
  localparam int BEAT_W    = ofs_width(LINE_BEATS) - 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [63:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [63:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [63:0]      data_mem [NUM_SETS*LINE_BEATS];
  logic [TAG_W-1:0] tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_idx, wr_beat}] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= data_mem[{rd_idx, rd_beat}];
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
    if (rd_en) begin
      rd_tag <= tag_mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (tag_we) begin
        valid_reg[wr_idx] <= 1'b1;
      end
      if (rd_en) begin
        rd_valid <= valid_reg[rd_idx];
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative read-only instruction cache.
//   Accepts one fetch at a time on ibus, looks the line up in the cycle after
//   acceptance and, on a miss, refills the whole line with one INCR burst on
//   cbus into the round-robin victim way before answering.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   ireq        fetch request (valid, addr)
//   iresp       addr_ok (combinational in IDLE), data_ok, data
//   creq        refill request to the interconnect
//   cresp       interconnect response (ready, last, data)
// Optional build macro ICACHE_UNCACHED_EN: addresses with addr[31] == 0 skip
// the cache and are fetched with a single 4-byte cbus read.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int OFS_W  = ofs_width(LINE_BEATS);
  localparam int IDX_W  = idx_width(NUM_SETS);
  localparam int BEAT_W = OFS_W - 3;
  localparam int TAG_W  = ADDR_W - OFS_W - IDX_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(NUM_WAYS - 1);
  localparam mlen_t LINE_LEN = mlen_t'(4'(LINE_BEATS - 1));

  icache_state_t state_reg, state_next;
  addr_t             addr_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [31:0]       word_reg;
  logic [WAY_W-1:0]  victim_reg;
  logic [WAY_W-1:0]  rr_ptr_reg [NUM_SETS];

  // Fields of the latched request.
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] beat_q;
  assign tag_q  = addr_reg[ADDR_W-1:OFS_W+IDX_W];
  assign idx_q  = addr_reg[OFS_W+IDX_W-1:OFS_W];
  assign beat_q = addr_reg[OFS_W-1:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_reg[1:0];

  logic accept;
  logic refill_beat;
  assign accept      = (state_reg == IDLE) && ireq.valid && !reset;
  assign refill_beat = (state_reg == REFILL) && cresp.ready && !reset;

  // Way storage; the read is launched on acceptance so tags and the
  // requested beat are ready in LOOKUP.
  logic [NUM_WAYS-1:0] way_hit;
  logic [NUM_WAYS-1:0] way_rvalid;
  logic [TAG_W-1:0]    way_rtag  [NUM_WAYS];
  logic [63:0]         way_rdata [NUM_WAYS];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    icache_way_ram #(
      .NUM_SETS   (NUM_SETS),
      .LINE_BEATS (LINE_BEATS),
      .TAG_W      (TAG_W)
    ) u_ram (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (accept),
      .rd_idx   (ireq.addr[OFS_W+IDX_W-1:OFS_W]),
      .rd_beat  (ireq.addr[OFS_W-1:3]),
      .rd_valid (way_rvalid[gi]),
      .rd_tag   (way_rtag[gi]),
      .rd_data  (way_rdata[gi]),
      .wr_en    (refill_beat && (victim_reg == WAY_W'(gi))),
      .wr_idx   (idx_q),
      .wr_beat  (beat_cnt_reg),
      .wr_data  (cresp.data),
      .tag_we   (refill_beat && cresp.last && (victim_reg == WAY_W'(gi))),
      .wr_tag   (tag_q)
    );
    assign way_hit[gi] = way_rvalid[gi] && (way_rtag[gi] == tag_q);
  end

  // At most one way can hit, so OR-ing the gated beats selects it.
  logic        hit;
  logic [63:0] hit_beat;
  always_comb begin
    hit_beat = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) begin
        hit_beat = hit_beat | way_rdata[w];
      end
    end
  end
  assign hit = |way_hit;

  // Next state and outputs.
  always_comb begin
    state_next = state_reg;
    iresp      = '0;
    creq       = '0;
    unique case (state_reg)
      IDLE: begin
        iresp.addr_ok = ireq.valid;
        if (ireq.valid) begin
          state_next = LOOKUP;
`ifdef ICACHE_UNCACHED_EN
          if (!ireq.addr[31]) begin
            state_next = UNCACHED;
          end
`endif
        end
      end
      LOOKUP: begin
        if (hit) begin
          iresp.data_ok = 1'b1;
          iresp.data    = addr_reg[2] ? hit_beat[63:32] : hit_beat[31:0];
          state_next    = IDLE;
        end else begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.len   = LINE_LEN;
        creq.burst = AXI_BURST_INCR;
        creq.addr  = {addr_reg[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        if (cresp.ready && cresp.last) begin
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        iresp.data_ok = 1'b1;
        iresp.data    = word_reg;
        state_next    = IDLE;
      end
`ifdef ICACHE_UNCACHED_EN
      UNCACHED: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.len   = MLEN1;
        creq.burst = AXI_BURST_INCR;
        creq.addr  = addr_reg;
        if (cresp.ready && cresp.last) begin
          iresp.data_ok = 1'b1;
          iresp.data    = addr_reg[2] ? cresp.data[63:32] : cresp.data[31:0];
          state_next    = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
    if (reset) begin
      iresp = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      beat_cnt_reg <= '0;
      word_reg     <= '0;
      victim_reg   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_ptr_reg[s] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= ireq.addr;
        beat_cnt_reg <= '0;
      end
      if ((state_reg == LOOKUP) && !hit) begin
        victim_reg <= rr_ptr_reg[idx_q];
      end
      if (refill_beat) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
        // Keep the requested word so RESPOND does not need another RAM read.
        if (beat_cnt_reg == beat_q) begin
          word_reg <= addr_reg[2] ? cresp.data[63:32] : cresp.data[31:0];
        end
        if (cresp.last) begin
          rr_ptr_reg[idx_q] <= (rr_ptr_reg[idx_q] == LAST_WAY) ? '0 : rr_ptr_reg[idx_q] + 1'b1;
        end
        // An early last would leave part of the line unwritten yet valid.
        if (cresp.last) begin
          assert (beat_cnt_reg == LAST_BEAT);
        end
      end
    end
  end

endmodule
